// File: rtl/sparse_buf_pkg.sv
// Shared definitions for the sparse tensor core operand buffer and its readers.
package sparse_buf_pkg;

  localparam int unsigned DATA_WIDTH   = 64;
  localparam int unsigned ADDR_WIDTH   = 64;
  localparam int unsigned BUFFER_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/buffer_reader.sv
// Read-side controller for the operand buffer: walks an address window over the
// buffer's combinational read port and presents the words as a valid/ready
// stream with a last flag, then pulses done.
module buffer_reader #(
  parameter int unsigned DATA_WIDTH   = sparse_buf_pkg::DATA_WIDTH,
  parameter int unsigned BUFFER_DEPTH = sparse_buf_pkg::BUFFER_DEPTH,
  parameter int unsigned ADDR_WIDTH   = sparse_buf_pkg::ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  buf_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  import sparse_buf_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BUFFER_DEPTH - 1);

  state_e                state_q;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  load;
  logic                  accept_last;

  // Read/load decision; the output register may refill in the same cycle it drains.
  always_comb begin
    load        = (state_q == STREAM) && (count_q < len_q) && (!out_valid || out_ready);
    accept_last = out_valid && out_ready && out_last;
    rd_en       = load;
    rd_addr     = (state_q == STREAM) ? addr_q : '0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:     if (start) state_nxt = (len == '0) ? DONE : WAIT_RDY;
      WAIT_RDY: if (buf_ready) state_nxt = STREAM;
      STREAM:   if (accept_last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM state, transfer bookkeeping and the output register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && start) begin
        addr_q  <= base_addr;
        len_q   <= len;
        count_q <= '0;
      end
      if (load) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
        out_last  <= (count_q == len_q - LEN_WIDTH'(1));
        count_q   <= count_q + LEN_WIDTH'(1);
        addr_q    <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench for buffer_reader: a behavioural buffer model drives rd_data,
// stimulus pushes expected beats/addresses, a negedge monitor pops and compares.
module tb_buffer_reader;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          buf_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int beat_cnt = 0;

  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_addr [$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  buffer_reader #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(DEPTH),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .buf_ready(buf_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Combinational buffer read port.
  always_comb rd_data = mem[rd_addr[5:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: beats, read addresses, stall stability, done pulses.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (prev_stall) chk("stall_rd_en", {63'd0, rd_en}, 64'd0);
      if (rd_en) begin
        if (exp_addr.size() == 0) chk("unexpected_read", rd_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_data.size() == 0) begin
          chk("unexpected_beat", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("beat_data", out_data, exp_data.pop_front());
          chk("beat_last", {63'd0, out_last}, {63'd0, exp_last.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  // Call at posedge+1; start is sampled by the next edge.
  task automatic start_xfer(input int base, input int n);
    start     = 1'b1;
    base_addr = AW'(base);
    len       = LW'(n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(mem[(base + i) % DEPTH]);
      exp_last.push_back(i == n - 1);
      exp_addr.push_back(AW'((base + i) % DEPTH));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int d0;
    int b0;
    bit pat [9] = '{1, 0, 0, 1, 0, 1, 1, 1, 1};

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(i);
    rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    buf_ready = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_rd_addr", rd_addr, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;
    tick();

    // Empty buffer: hold in WAIT_RDY, ignore a second start, stream after ready.
    d0 = done_cnt;
    start_xfer(20, 3);
    for (int i = 0; i < 4; i++) begin
      chk("wait_busy", {63'd0, busy}, 64'd1);
      chk("wait_rd_en", {63'd0, rd_en}, 64'd0);
      chk("wait_valid", {63'd0, out_valid}, 64'd0);
      if (i == 1) begin
        start = 1'b1; base_addr = 64'd40; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    buf_ready = 1'b1;
    wait_valid(n);
    chk("ready_latency", 64'(n), 64'd2);
    wait_done(d0, "done_after_wait");
    chk("queue_empty_wait", 64'(exp_data.size()), 64'd0);

    // Basic len=4 from 0: latency, back-to-back beats, done, busy.
    tick();
    d0 = done_cnt;
    start_xfer(0, 4);
    chk("t1_busy_after_start", {63'd0, busy}, 64'd1);
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("t1_consecutive", {63'd0, out_valid}, 64'd1);
      tick();
    end
    chk("t1_done", {63'd0, done}, 64'd1);
    tick();
    chk("t1_busy_low", {63'd0, busy}, 64'd0);
    chk("t1_done_once", 64'(done_cnt), 64'(d0 + 1));

    // Address wrap.
    d0 = done_cnt;
    start_xfer(62, 4);
    wait_done(d0, "wrap_done");
    chk("wrap_addr_empty", 64'(exp_addr.size()), 64'd0);
    tick();

    // Backpressure pattern, len=6.
    d0 = done_cnt;
    b0 = beat_cnt;
    start_xfer(10, 6);
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'd2);
    for (int i = 0; i < 9; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_done(d0, "bp_done");
    chk("bp_beats", 64'(beat_cnt - b0), 64'd6);
    tick();

    // len=0: no beats, one done pulse.
    d0 = done_cnt;
    b0 = beat_cnt;
    start_xfer(7, 0);
    chk("len0_busy", {63'd0, busy}, 64'd1);
    chk("len0_done", {63'd0, done}, 64'd1);
    tick();
    chk("len0_busy_low", {63'd0, busy}, 64'd0);
    repeat (3) tick();
    chk("len0_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    chk("len0_no_beats", 64'(beat_cnt - b0), 64'd0);

    // Reset mid-transfer after three beats of len=8.
    d0 = done_cnt;
    b0 = beat_cnt;
    start_xfer(30, 8);
    n = 0;
    while (beat_cnt < b0 + 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", 64'(beat_cnt - b0), 64'd3);
    #2 rstn = 1'b0;
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_last", {63'd0, out_last}, 64'd0);
    chk("abort_rd_en", {63'd0, rd_en}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    d0 = done_cnt;
    start_xfer(5, 2);
    wait_done(d0, "post_reset_done");
    chk("post_reset_empty", 64'(exp_data.size()), 64'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
